// File: rtl/neuron_accum.sv
// neuron_accum: serial float32 accumulator with bias and step activation.
// Products arrive one at a time over a valid/ready handshake. Each one is
// added to the running sum (the bias seeds the sum on the first product)
// through a fixed-latency pipelined float adder. After NUM_IN products the
// sum and its fire decision are held until the downstream accepts them.
// fp_adder is a bit-compatible stand-in for the IP: round-to-nearest-even,
// subnormals supported, NaN/Inf handled in the usual IEEE way.

module fp_adder #(
   parameter int LAT = 7
) (
   input  logic        clock,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic [31:0] result
);
   logic [31:0] sum_d;
   logic [31:0] pipe_q [LAT];

   logic        a_ge, a_nan, b_nan, a_inf, b_inf, sticky, up;
   logic [31:0] big, sml;
   logic [7:0]  e_big, e_sml, d, exp_f;
   logic [23:0] sig_big, sig_sml;
   logic [27:0] ext_big, ext_sml, sh_sml, raw;
   logic [26:0] norm;
   logic [9:0]  exp_w;
   logic [4:0]  lz, shamt;
   logic [24:0] rnd;
   logic [22:0] mant;

   // Position of the leading one, counted from bit 26; 27 when all zero.
   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd27;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found && v[i]) begin
            n     = 5'(26 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

   // Align, add/subtract, normalise, round; specials override the result.
   always_comb begin
      a_nan   = (dataa[30:23] == 8'hFF) && (dataa[22:0] != 23'd0);
      b_nan   = (datab[30:23] == 8'hFF) && (datab[22:0] != 23'd0);
      a_inf   = (dataa[30:23] == 8'hFF) && (dataa[22:0] == 23'd0);
      b_inf   = (datab[30:23] == 8'hFF) && (datab[22:0] == 23'd0);
      a_ge    = (dataa[30:0] >= datab[30:0]);
      big     = a_ge ? dataa : datab;
      sml     = a_ge ? datab : dataa;
      // Subnormals use exponent 1 without the hidden bit.
      e_big   = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
      e_sml   = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
      sig_big = {(big[30:23] != 8'd0), big[22:0]};
      sig_sml = {(sml[30:23] != 8'd0), sml[22:0]};
      d       = e_big - e_sml;
      ext_big = {1'b0, sig_big, 3'b000};
      ext_sml = {1'b0, sig_sml, 3'b000};
      if (d >= 8'd28) begin
         sh_sml = 28'd0;
         sticky = |sig_sml;
      end else begin
         sh_sml = ext_sml >> d;
         sticky = |(ext_sml & ((28'd1 << d) - 28'd1));
      end
      sh_sml[0] = sh_sml[0] | sticky;
      raw   = (big[31] ^ sml[31]) ? (ext_big - sh_sml) : (ext_big + sh_sml);
      exp_w = {2'b00, e_big};
      lz    = 5'd0;
      shamt = 5'd0;
      if (raw[27]) begin
         norm  = {raw[27:2], raw[1] | raw[0]};
         exp_w = exp_w + 10'd1;
      end else begin
         norm = raw[26:0];
         lz   = lzc27(norm);
         // Stop shifting at the subnormal boundary.
         if ({5'd0, lz} < exp_w) shamt = lz;
         else                    shamt = exp_w[4:0] - 5'd1;
         norm  = norm << shamt;
         exp_w = exp_w - {5'd0, shamt};
      end
      up  = norm[2] & (norm[1] | norm[0] | norm[3]);
      rnd = {1'b0, norm[26:3]} + {24'd0, up};
      if (rnd[24]) begin
         exp_w = exp_w + 10'd1;
         exp_f = exp_w[7:0];
         mant  = 23'd0;
      end else begin
         exp_f = rnd[23] ? exp_w[7:0] : 8'd0;
         mant  = rnd[22:0];
      end
      if (a_nan)                                       sum_d = dataa | 32'h0040_0000;
      else if (b_nan)                                  sum_d = datab | 32'h0040_0000;
      else if (a_inf && b_inf && (dataa[31] != datab[31])) sum_d = 32'h7FC0_0000;
      else if (a_inf)                                  sum_d = dataa;
      else if (b_inf)                                  sum_d = datab;
      else if (raw == 28'd0)                           sum_d = {big[31] & sml[31], 31'd0};
      else if (exp_w >= 10'd255)                       sum_d = {big[31], 8'hFF, 23'd0};
      else                                             sum_d = {big[31], exp_f, mant};
   end

   // Fixed-latency delay line: result lags the operands by LAT edges.
   always_ff @(posedge clock) begin
      pipe_q[0] <= sum_d;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
   end

   assign result = pipe_q[LAT-1];
endmodule

module neuron_accum #(
   parameter int NUM_IN  = 2,
   parameter int ADD_LAT = 7
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic [31:0] iDATA,
   input  logic        iVALID,
   output logic        oREADY,
   input  logic [31:0] iBIAS,
   output logic [31:0] oSUM,
   output logic        oFIRE,
   output logic        oVALID,
   input  logic        iREADY
);
   localparam int CW = $clog2(NUM_IN + 1);
   localparam int WW = $clog2(ADD_LAT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [31:0]   acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [31:0]   opa_q, opa_d;
   logic [31:0]   opb_q, opb_d;
   logic          fire_q, fire_d;
   logic [31:0]   add_result;

   // Positive, non-zero and not NaN; +Inf fires.
   function automatic logic step(input logic [31:0] x);
      return !x[31] && (x[30:0] != 31'd0) &&
             !((x[30:23] == 8'hFF) && (x[22:0] != 23'd0));
   endfunction

   fp_adder #(.LAT(ADD_LAT)) u_add (
      .clock  (iCLK),
      .dataa  (opa_q),
      .datab  (opb_q),
      .result (add_result)
   );

   assign cnt_inc = cnt_q + CW'(1);

   // Next-state: accept a product, wait out the adder, then present the result.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      fire_d  = fire_q;
      case (state_q)
         S_IDLE: begin
            if (iVALID) begin
               // Bias seeds the sum only on the first product of a sample.
               opa_d   = (cnt_q == '0) ? iBIAS : acc_q;
               opb_d   = iDATA;
               wcnt_d  = WW'(ADD_LAT);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wcnt_q == '0) begin
               acc_d = add_result;
               cnt_d = cnt_inc;
               if (cnt_inc == CW'(NUM_IN)) begin
                  fire_d  = step(add_result);
                  state_d = S_DONE;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               wcnt_d = wcnt_q - WW'(1);
            end
         end
         S_DONE: begin
            if (iREADY) begin
               cnt_d   = '0;
               fire_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any partial sample.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= S_IDLE;
         acc_q   <= 32'd0;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         opa_q   <= 32'd0;
         opb_q   <= 32'd0;
         fire_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         fire_q  <= fire_d;
      end
   end

   assign oREADY = (state_q == S_IDLE);
   assign oVALID = (state_q == S_DONE);
   assign oSUM   = acc_q;
   assign oFIRE  = fire_q;
endmodule

// File: tb/tb_neuron_accum.sv
// Directed bench for neuron_accum (NUM_IN=2, ADD_LAT=7).
module tb_neuron_accum;
   localparam int NUM_IN  = 2;
   localparam int ADD_LAT = 7;

   logic        iCLK, iRST_N, iVALID, oREADY, oFIRE, oVALID, iREADY;
   logic [31:0] iDATA, iBIAS, oSUM;
   int          total, bad, cyc;

   neuron_accum #(.NUM_IN(NUM_IN), .ADD_LAT(ADD_LAT)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iVALID(iVALID),
      .oREADY(oREADY), .iBIAS(iBIAS), .oSUM(oSUM), .oFIRE(oFIRE),
      .oVALID(oVALID), .iREADY(iREADY)
   );

   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   initial cyc = 0;
   always @(posedge iCLK) cyc <= cyc + 1;

   // Offer one product and hold it until accepted; returns just after the accepting edge.
   task automatic send(input logic [31:0] d);
      bit done;
      done = 1'b0;
      @(negedge iCLK);
      iDATA  = d;
      iVALID = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         if (oREADY) begin
            @(posedge iCLK);
            done = 1'b1;
         end else begin
            @(negedge iCLK);
         end
      end
      #1 iVALID = 1'b0;
      if (!done) begin
         total++; bad++;
         $display("FAIL send_timeout: accepted=0 required=1");
      end
   endtask

   // Count negedges until oVALID is seen, bounded.
   task automatic wait_result(output logic [31:0] sum, output logic fire, output int lat);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      sum  = 32'hDEAD_BEEF;
      fire = 1'bx;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge iCLK);
         lat++;
         if (oVALID) begin
            seen = 1'b1;
            sum  = oSUM;
            fire = oFIRE;
         end
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL result_timeout: ovalid=0 required=1");
      end
   endtask

   task automatic run_sample(input logic [31:0] bias, input logic [31:0] p0, input logic [31:0] p1,
                             output logic [31:0] sum, output logic fire, output int lat);
      iBIAS = bias;
      send(p0);
      send(p1);
      wait_result(sum, fire, lat);
   endtask

   // Complete the DONE handshake (iREADY is high) and land just after the edge.
   task automatic finish_handshake();
      iREADY = 1'b1;
      @(posedge iCLK);
      #1;
   endtask

   task automatic test_reset();
      iRST_N = 1'b0;
      iVALID = 1'b1;
      iDATA  = $urandom;
      iBIAS  = $urandom;
      iREADY = 1'b0;
      repeat (3) @(negedge iCLK);
      total++;
      if (oVALID !== 1'b0) begin bad++; $display("FAIL reset_ovalid_in_reset: got=%b want=0", oVALID); end
      iVALID = 1'b0;
      iRST_N = 1'b1;
      iREADY = 1'b1;
      @(negedge iCLK);
      total++;
      if (oREADY !== 1'b1) begin bad++; $display("FAIL reset_oready: got=%b want=1", oREADY); end
      total++;
      if (oVALID !== 1'b0) begin bad++; $display("FAIL reset_ovalid: got=%b want=0", oVALID); end
      total++;
      if (oFIRE !== 1'b0) begin bad++; $display("FAIL reset_ofire: got=%b want=0", oFIRE); end
      total++;
      if (oSUM !== 32'h0) begin bad++; $display("FAIL reset_osum: got=%h want=00000000", oSUM); end
      $display("reset: oready=%b ovalid=%b osum=%h", oREADY, oVALID, oSUM);
   endtask

   task automatic test_fire();
      logic [31:0] s; logic f; int lat;
      iREADY = 1'b1;
      run_sample(32'hBFC0_0000, 32'h3F80_0000, 32'h3F80_0000, s, f, lat);
      total++;
      if (s !== 32'h3F00_0000) begin bad++; $display("FAIL fire_sum: got=%h want=3f000000", s); end
      total++;
      if (f !== 1'b1) begin bad++; $display("FAIL fire_fire: got=%b want=1", f); end
      total++;
      if (lat != ADD_LAT + 2) begin bad++; $display("FAIL fire_latency: got=%0d want=%0d", lat, ADD_LAT + 2); end
      finish_handshake();
      total++;
      if (oVALID !== 1'b0 || oREADY !== 1'b1) begin
         bad++; $display("FAIL fire_after_handshake: ovalid=%b oready=%b want ovalid=0 oready=1", oVALID, oREADY);
      end
      $display("fire: sum=%h fire=%b latency=%0d", s, f, lat);
   endtask

   task automatic test_nofire();
      logic [31:0] s; logic f; int lat;
      logic [31:0] vb [5] = '{32'hBFC0_0000, 32'hBFC0_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000};
      logic [31:0] v0 [5] = '{32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h8000_0000};
      logic [31:0] v1 [5] = '{32'h3F80_0000, 32'h3F00_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h8000_0000};
      logic [31:0] es [5] = '{32'hBF00_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000};
      logic        ef [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int k = 0; k < 5; k++) begin
         run_sample(vb[k], v0[k], v1[k], s, f, lat);
         total++;
         if (s !== es[k]) begin bad++; $display("FAIL case%0d_sum: got=%h want=%h", k, s, es[k]); end
         total++;
         if (f !== ef[k]) begin bad++; $display("FAIL case%0d_fire: got=%b want=%b", k, f, ef[k]); end
         $display("case%0d: bias=%h p0=%h p1=%h sum=%h fire=%b", k, vb[k], v0[k], v1[k], s, f);
         finish_handshake();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] s; logic f; int lat; int k; int acc_cyc [2];
      logic [31:0] prod [2] = '{32'h3F80_0000, 32'h3F80_0000};
      k = 0;
      acc_cyc[0] = 0; acc_cyc[1] = 0;
      iBIAS  = 32'hBFC0_0000;
      iVALID = 1'b1;
      for (int c = 0; c < 60 && k < 2; c++) begin
         @(negedge iCLK);
         if (oREADY) begin
            iDATA = prod[k];
            acc_cyc[k] = cyc;
            k++;
         end else begin
            // Large junk that would corrupt the sum if it were absorbed.
            iDATA = 32'h4B00_0000 + 32'(c);
         end
      end
      @(posedge iCLK);
      #1 iVALID = 1'b0;
      total++;
      if (k != 2) begin bad++; $display("FAIL b2b_accepts: got=%0d want=2", k); end
      total++;
      if (acc_cyc[1] - acc_cyc[0] != ADD_LAT + 2) begin
         bad++; $display("FAIL b2b_spacing: got=%0d want=%0d", acc_cyc[1] - acc_cyc[0], ADD_LAT + 2);
      end
      wait_result(s, f, lat);
      total++;
      if (s !== 32'h3F00_0000) begin bad++; $display("FAIL b2b_sum: got=%h want=3f000000", s); end
      total++;
      if (f !== 1'b1) begin bad++; $display("FAIL b2b_fire: got=%b want=1", f); end
      $display("b2b: spacing=%0d sum=%h fire=%b", acc_cyc[1] - acc_cyc[0], s, f);
      finish_handshake();
   endtask

   task automatic test_backpressure();
      logic [31:0] s; logic f; int lat; int unstable; int rdy_hi;
      iREADY = 1'b0;
      iBIAS  = 32'hBFC0_0000;
      send(32'h3F80_0000);
      iBIAS  = 32'h4120_0000;   // changed mid-sample: must not matter
      send(32'h3F80_0000);
      iBIAS  = 32'hC2C8_0000;
      wait_result(s, f, lat);
      total++;
      if (s !== 32'h3F00_0000 || f !== 1'b1) begin
         bad++; $display("FAIL bp_first_result: sum=%h fire=%b want sum=3f000000 fire=1", s, f);
      end
      unstable = 0;
      rdy_hi   = 0;
      iVALID   = 1'b1;
      iDATA    = 32'h4000_0000;
      for (int i = 0; i < 10; i++) begin
         @(negedge iCLK);
         if (oVALID !== 1'b1 || oSUM !== 32'h3F00_0000 || oFIRE !== 1'b1) unstable++;
         if (oREADY !== 1'b0) rdy_hi++;
      end
      iVALID = 1'b0;
      total++;
      if (unstable != 0) begin bad++; $display("FAIL bp_stable: unstable_cycles=%0d want=0", unstable); end
      total++;
      if (rdy_hi != 0) begin bad++; $display("FAIL bp_oready_in_done: high_cycles=%0d want=0", rdy_hi); end
      $display("backpressure: held 10 cycles sum=%h fire=%b", oSUM, oFIRE);
      finish_handshake();
      run_sample(32'hC000_0000, 32'h3F80_0000, 32'h3F00_0000, s, f, lat);
      total++;
      if (s !== 32'hBF00_0000) begin bad++; $display("FAIL bp_new_bias_sum: got=%h want=bf000000", s); end
      total++;
      if (f !== 1'b0) begin bad++; $display("FAIL bp_new_bias_fire: got=%b want=0", f); end
      $display("new bias: sum=%h fire=%b", s, f);
      finish_handshake();
   endtask

   task automatic test_reset_mid();
      logic [31:0] s; logic f; int lat; int vseen;
      iREADY = 1'b1;
      iBIAS  = 32'hBFC0_0000;
      send(32'h3F80_0000);
      send(32'h3F80_0000);
      repeat (3) @(negedge iCLK);
      iRST_N = 1'b0;
      @(negedge iCLK);
      iRST_N = 1'b1;
      vseen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge iCLK);
         if (oVALID) vseen++;
      end
      total++;
      if (vseen != 0) begin bad++; $display("FAIL midrst_no_valid: valid_cycles=%0d want=0", vseen); end
      total++;
      if (oSUM !== 32'h0 || oREADY !== 1'b1) begin
         bad++; $display("FAIL midrst_outputs: osum=%h oready=%b want osum=00000000 oready=1", oSUM, oREADY);
      end
      run_sample(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, s, f, lat);
      total++;
      if (s !== 32'h4040_0000) begin bad++; $display("FAIL midrst_sum: got=%h want=40400000", s); end
      total++;
      if (f !== 1'b1) begin bad++; $display("FAIL midrst_fire: got=%b want=1", f); end
      $display("reset mid-sample: fresh sum=%h fire=%b", s, f);
      finish_handshake();
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      iRST_N = 1'b0;
      iVALID = 1'b0;
      iREADY = 1'b1;
      iDATA  = 32'h0;
      iBIAS  = 32'h0;
      test_reset();
      test_fire();
      test_nofire();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
